magnitude_stream: RTL and testbench
===================================

// Module: magnitude_stream
// PURPOSE
//  Streaming, parametrised two's-complement magnitude unit for the FIR datapath.
//  Converts signed (WIDTH+1)-bit samples to WIDTH-bit unsigned magnitudes.
//  Uses a 2-stage valid/ready pipeline with selectable saturate/wrap on the
//  most-negative input, plus running peak magnitude, sticky overflow flag
//  and transferred-sample counter. Sits between the accumulator and the
//  output sync/serialiser.
// PARAMETERS
//  WIDTH     16  magnitude width; input is WIDTH+1 bits signed
//  SATURATE  1   1: -2^WIDTH -> all ones; 0: -2^WIDTH -> 0 (wrap, legacy result)
//  CNT_W     8   width of sample_count
// PORTS
//  clk           in   1        system clock, rising edge
//  n_rst         in   1        async active-low reset
//  clear         in   1        sync clear: flush pipeline, zero peak/ovf/count
//  in_valid      in   1        in_data valid
//  in_data       in   WIDTH+1  signed two's-complement sample
//  in_ready      out  1        block can accept in_data this cycle
//  out_valid     out  1        out_mag/out_neg valid
//  out_ready     in   1        downstream accepts output this cycle
//  out_mag       out  WIDTH    |in_data|, saturated/wrapped per SATURATE
//  out_neg       out  1        sign bit of the originating sample
//  peak_mag      out  WIDTH    max out_mag transferred since reset/clear
//  ovf_flag      out  1        sticky: a -2^WIDTH sample was transferred out
//  sample_count  out  CNT_W    outputs transferred since reset/clear, wraps
// BEHAVIOUR
//  - Reset (n_rst=0, async): all valids 0, out_mag 0, out_neg 0, peak_mag 0,
//    ovf_flag 0, sample_count 0. in_ready=1 one cycle after reset release.
//  - Stage 1 (S1) registers in_data. Stage 2 (S2) registers the magnitude
//    and drives out_*. Each stage has its own valid bit.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - S2 loads when S1 valid and (S2 empty or S2 transferring out).
//  - S1 loads when in transfer; in_ready = !S1v | S2 loads this cycle.
//  - in_ready is independent of in_valid (no combinational loop).
//  - Latency: 2 cycles from input transfer to out_valid with no backpressure.
//    Full throughput is 1 sample/cycle while out_ready=1.
//  - Under stall, out_mag, out_neg and out_valid hold stable. Up to 2 samples
//    are buffered. No loss, no duplication, order is preserved.
//  - Magnitude: sign=0 -> in[WIDTH-1:0]; sign=1 -> (~in + 1) truncated to WIDTH.
//    in = -2^WIDTH (sign=1, rest 0): SATURATE=1 -> {WIDTH{1}}, SATURATE=0 -> 0.
//  - Stats update only on output transfer:
//    - sample_count += 1, wrapping 2^CNT_W-1 -> 0.
//    - peak_mag = max(peak_mag, out_mag).
//    - ovf_flag sets if the transferred sample was -2^WIDTH (either mode).
//  - clear=1 has priority over everything:
//    - next cycle: S1v=S2v=0, peak_mag=0, ovf_flag=0, sample_count=0.
//    - in_ready=0 during the clear cycle; no input is accepted.
//    - an output handshake in the clear cycle does not update stats.
//  - n_rst asserted mid-stream: immediate flush of all state. No partial
//    output appears after release.
// TESTING
//  - Reset: drive n_rst=0 mid-stream with out_valid=1 -> out_valid=0,
//    out_mag=0, peak/ovf/count=0 immediately.
//  - Basic (WIDTH=16): inputs 0x00005, 0x1FFFB, 0x0FFFF, 0x10001, out_ready=1
//    -> out_mag 5, 5, 0xFFFF, 0xFFFF, each 2 cycles after its input.
//    out_neg = 0, 1, 0, 1.
//  - Most-negative: in 0x10000 -> SATURATE=1 gives 0xFFFF; SATURATE=0 gives
//    0x0000. ovf_flag=1 after the transfer in both modes.
//  - Backpressure: stream 1..6 with out_ready=0 for 4 cycles -> in_ready
//    drops after 2 accepted. out_mag holds 1. On release, outputs 1..6
//    appear in order, none lost.
//  - Stats: magnitudes 3, 9, 4 transferred -> peak_mag=9, sample_count=3.
//    CNT_W=2 with 5 transfers -> sample_count=1.
//  - Clear: assert clear with 2 buffered samples and in_valid=1 -> in_ready=0.
//    Next cycle out_valid=0, peak_mag=0, count=0, ovf_flag=0.

Source files
------------

// File: rtl/magnitude_stream.sv
// Purpose : streaming two's-complement magnitude unit, (WIDTH+1)-bit signed in,
//           WIDTH-bit unsigned magnitude out, with peak / overflow / count stats.
// Latency : 2 cycles from input transfer to out_valid; 1 sample/cycle throughput.
// Backpr. : valid/ready on both sides, up to 2 samples buffered, outputs hold while
//           stalled; clear flushes the pipe and blocks input for that cycle.
//
// Ports
//   clk, n_rst            rising-edge clock, async active-low reset
//   clear                 sync flush of both stages and all statistics
//   in_valid/in_ready     input handshake, in_data is the signed sample
//   out_valid/out_ready   output handshake, out_mag/out_neg carry the result
//   peak_mag              largest out_mag transferred since reset/clear
//   ovf_flag              sticky, set when a -2^WIDTH sample is transferred out
//   sample_count          number of output transfers, wraps at 2^CNT_W
module magnitude_stream #(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH:0]   in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mag,
   output logic             out_neg,
   output logic [WIDTH-1:0] peak_mag,
   output logic             ovf_flag,
   output logic [CNT_W-1:0] sample_count
);

   // Stage 1: raw sample
   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH:0]   s1_dat_q, s1_dat_d;
   // Stage 2: magnitude, sign and most-negative marker
   logic             s2_vld_q, s2_vld_d;
   logic [WIDTH-1:0] s2_mag_q, s2_mag_d;
   logic             s2_neg_q, s2_neg_d;
   logic             s2_min_q, s2_min_d;
   // Statistics
   logic [WIDTH-1:0] peak_q, peak_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Holds in_ready low until the first clock after reset release
   logic             rdy_en_q;

   logic             in_xfer;
   logic             out_xfer;
   logic             s2_load;
   logic [WIDTH:0]   neg_val;
   logic             is_min;
   logic [WIDTH-1:0] mag;

   // S2 frees up either because it is empty or because it drains this cycle.
   // in_ready depends only on state, out_ready and clear -- never on in_valid.
   assign s2_load  = s1_vld_q & (~s2_vld_q | out_ready);
   assign in_ready = rdy_en_q & ~clear & (~s1_vld_q | s2_load);
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = s2_vld_q & out_ready;

   // Two's-complement negation; for -2^WIDTH the truncated result is 0 (wrap).
   assign neg_val = ~s1_dat_q + {{WIDTH{1'b0}}, 1'b1};
   assign is_min  = s1_dat_q[WIDTH] & ~(|s1_dat_q[WIDTH-1:0]);

   always_comb begin
      mag = s1_dat_q[WIDTH-1:0];
      if (s1_dat_q[WIDTH]) begin
         if (is_min) begin
            mag = SATURATE ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
         end else begin
            mag = neg_val[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_dat_d = s1_dat_q;
      s2_vld_d = s2_vld_q;
      s2_mag_d = s2_mag_q;
      s2_neg_d = s2_neg_q;
      s2_min_d = s2_min_q;
      peak_d   = peak_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;

      if (in_xfer) begin
         s1_dat_d = in_data;
      end
      if (s2_load) begin
         s2_mag_d = mag;
         s2_neg_d = s1_dat_q[WIDTH];
         s2_min_d = is_min;
      end

      if (clear) begin
         // Data registers keep their contents; only valids and stats reset.
         s1_vld_d = 1'b0;
         s2_vld_d = 1'b0;
         peak_d   = '0;
         ovf_d    = 1'b0;
         cnt_d    = '0;
      end else begin
         if (in_xfer) begin
            s1_vld_d = 1'b1;
         end else if (s2_load) begin
            s1_vld_d = 1'b0;
         end

         if (s2_load) begin
            s2_vld_d = 1'b1;
         end else if (out_xfer) begin
            s2_vld_d = 1'b0;
         end

         if (out_xfer) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (s2_mag_q > peak_q) begin
               peak_d = s2_mag_q;
            end
            if (s2_min_q) begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rdy_en_q <= 1'b0;
         s1_vld_q <= 1'b0;
         s1_dat_q <= '0;
         s2_vld_q <= 1'b0;
         s2_mag_q <= '0;
         s2_neg_q <= 1'b0;
         s2_min_q <= 1'b0;
         peak_q   <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         s1_vld_q <= s1_vld_d;
         s1_dat_q <= s1_dat_d;
         s2_vld_q <= s2_vld_d;
         s2_mag_q <= s2_mag_d;
         s2_neg_q <= s2_neg_d;
         s2_min_q <= s2_min_d;
         peak_q   <= peak_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid    = s2_vld_q;
   assign out_mag      = s2_mag_q;
   assign out_neg      = s2_neg_q;
   assign peak_mag     = peak_q;
   assign ovf_flag     = ovf_q;
   assign sample_count = cnt_q;

endmodule

// File: tb/tb_magnitude_stream.sv
// Purpose : directed bench for magnitude_stream; one saturating instance (CNT_W=8)
//           and one wrapping instance (CNT_W=2) driven by the same stimulus.
// Latency : checks the 2-cycle input-to-output latency when unstalled.
// Backpr. : exercises output stalls, clear with buffered data and mid-stream reset.
module tb_magnitude_stream;

   logic        clk;
   logic        n_rst;
   logic        clear;
   logic        in_valid;
   logic [16:0] in_data;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_neg, a_ovf;
   logic [15:0] a_out_mag, a_peak;
   logic [7:0]  a_cnt;

   logic        b_in_ready, b_out_valid, b_out_neg, b_ovf;
   logic [15:0] b_out_mag, b_peak;
   logic [1:0]  b_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [16:0] stim_q [$];
   logic [15:0] expa_q [$];
   logic [15:0] expb_q [$];
   logic        neg_q  [$];

   magnitude_stream #(.WIDTH(16), .SATURATE(1'b1), .CNT_W(8)) u_sat (
      .clk(clk), .n_rst(n_rst), .clear(clear),
      .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_mag(a_out_mag), .out_neg(a_out_neg),
      .peak_mag(a_peak), .ovf_flag(a_ovf), .sample_count(a_cnt)
   );

   magnitude_stream #(.WIDTH(16), .SATURATE(1'b0), .CNT_W(2)) u_wrap (
      .clk(clk), .n_rst(n_rst), .clear(clear),
      .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_mag(b_out_mag), .out_neg(b_out_neg),
      .peak_mag(b_peak), .ovf_flag(b_ovf), .sample_count(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [16:0] s, input logic [15:0] ea, input logic [15:0] eb,
                       input logic neg);
      stim_q.push_back(s);
      expa_q.push_back(ea);
      expb_q.push_back(eb);
      neg_q.push_back(neg);
   endtask

   // Streams the queued samples; out_ready is held low for the first 'stall' cycles.
   task automatic run_stream(input int stall);
      int n, sent, got, cyc;
      int acc_cyc [16];
      n = stim_q.size();
      sent = 0;
      got = 0;
      cyc = 0;
      while (got < n && cyc < 100) begin
         in_valid  = (sent < n);
         in_data   = (sent < n) ? stim_q[sent] : 17'h0;
         out_ready = (cyc >= stall);
         #1;
         if (stall > 0 && cyc == stall - 1) begin
            check_eq("bp_accepted", sent, 2);
            check_eq("bp_in_ready", a_in_ready, 0);
            check_eq("bp_hold_vld", a_out_valid, 1);
            check_eq("bp_hold_mag", a_out_mag, expa_q[0]);
         end
         if (a_out_valid && out_ready) begin
            check_eq("mag_sat", a_out_mag, expa_q[got]);
            check_eq("mag_wrap", b_out_mag, expb_q[got]);
            check_eq("neg", a_out_neg, neg_q[got]);
            if (stall == 0) check_eq("latency", cyc - acc_cyc[got], 2);
            got++;
         end
         if (in_valid && a_in_ready) begin
            acc_cyc[sent] = cyc;
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check_eq("stream_done", got, n);
      stim_q.delete();
      expa_q.delete();
      expb_q.delete();
      neg_q.delete();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      n_rst     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 17'h0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b1;
      tick();
      tick();

      // Reset state
      check_eq("rst_in_ready", a_in_ready, 1);
      check_eq("rst_out_valid", a_out_valid, 0);
      check_eq("rst_out_mag", a_out_mag, 0);
      check_eq("rst_peak", a_peak, 0);
      check_eq("rst_ovf", a_ovf, 0);
      check_eq("rst_cnt", a_cnt, 0);

      // Basic conversion, unstalled
      push(17'h00005, 16'h0005, 16'h0005, 1'b0);
      push(17'h1FFFB, 16'h0005, 16'h0005, 1'b1);
      push(17'h0FFFF, 16'hFFFF, 16'hFFFF, 1'b0);
      push(17'h10001, 16'hFFFF, 16'hFFFF, 1'b1);
      run_stream(0);
      check_eq("basic_cnt_sat", a_cnt, 4);
      check_eq("basic_cnt_wrap", b_cnt, 0);
      check_eq("basic_peak", a_peak, 16'hFFFF);
      check_eq("basic_ovf", a_ovf, 0);
      check_eq("basic_drained", a_out_valid, 0);

      // Statistics after a clear: magnitudes 3, 9, 4
      do_clear();
      push(17'h00003, 16'd3, 16'd3, 1'b0);
      push(17'h1FFF7, 16'd9, 16'd9, 1'b1);
      push(17'h00004, 16'd4, 16'd4, 1'b0);
      run_stream(0);
      check_eq("stats_peak", a_peak, 9);
      check_eq("stats_cnt", a_cnt, 3);
      push(17'h00001, 16'd1, 16'd1, 1'b0);
      push(17'h00002, 16'd2, 16'd2, 1'b0);
      run_stream(0);
      check_eq("stats_peak_keep", a_peak, 9);
      check_eq("stats_cnt5", a_cnt, 5);
      check_eq("stats_cnt_wrap", b_cnt, 1);

      // Most-negative input
      push(17'h10000, 16'hFFFF, 16'h0000, 1'b1);
      run_stream(0);
      check_eq("min_ovf_sat", a_ovf, 1);
      check_eq("min_ovf_wrap", b_ovf, 1);
      check_eq("min_peak_sat", a_peak, 16'hFFFF);
      check_eq("min_peak_wrap", b_peak, 9);

      // Clear with two samples buffered and input pending
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 17'h00011;
      tick();
      in_data = 17'h00012;
      tick();
      in_data = 17'h00013;
      clear   = 1'b1;
      #1;
      check_eq("clr_buffered_vld", a_out_valid, 1);
      check_eq("clr_buffered_mag", a_out_mag, 16'h0011);
      check_eq("clr_in_ready", a_in_ready, 0);
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_eq("clr_out_valid", a_out_valid, 0);
      check_eq("clr_peak", a_peak, 0);
      check_eq("clr_cnt", a_cnt, 0);
      check_eq("clr_ovf", a_ovf, 0);
      check_eq("clr_ovf_wrap", b_ovf, 0);
      out_ready = 1'b1;
      tick();
      tick();
      check_eq("clr_nothing_taken", a_out_valid, 0);

      // Backpressure: 1..6 with out_ready low for 4 cycles
      for (int i = 1; i <= 6; i++) begin
         push(17'(i), 16'(i), 16'(i), 1'b0);
      end
      run_stream(4);
      check_eq("bp_cnt", a_cnt, 6);
      check_eq("bp_peak", a_peak, 6);

      // Mid-stream reset with data in flight and ovf set
      push(17'h10000, 16'hFFFF, 16'h0000, 1'b1);
      run_stream(0);
      check_eq("pre_rst_cnt", a_cnt, 7);
      in_valid  = 1'b1;
      in_data   = 17'h00007;
      out_ready = 1'b0;
      tick();
      tick();
      in_valid = 1'b0;
      #1;
      check_eq("pre_rst_vld", a_out_valid, 1);
      check_eq("pre_rst_mag", a_out_mag, 7);
      check_eq("pre_rst_ovf", a_ovf, 1);
      n_rst = 1'b0;
      #1;
      check_eq("mid_rst_vld", a_out_valid, 0);
      check_eq("mid_rst_mag", a_out_mag, 0);
      check_eq("mid_rst_peak", a_peak, 0);
      check_eq("mid_rst_ovf", a_ovf, 0);
      check_eq("mid_rst_cnt", a_cnt, 0);
      check_eq("mid_rst_cnt_wrap", b_cnt, 0);
      tick();
      tick();
      n_rst     = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      check_eq("post_rst_vld", a_out_valid, 0);
      check_eq("post_rst_in_ready", a_in_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
